dma_pkt_fifo_exmem: RTL and testbench
=====================================

# dma_pkt_fifo_exmem

Packet-aware, store-and-forward receive FIFO for the MAC-to-DMA path. Its buffer lives in an external single-port-per-direction memory. Words become visible to the DMA read side only after a complete, error-free packet has been committed. Overflowing or errored packets are rewound and dropped without ever reaching the reader. It replaces the word-level DMA FIFO with parametrised width and depth, a valid/ready read side with full throughput across the 1-cycle memory read latency, and packet accounting.

## Interface
Parameters:
- DWIDTH, 64: data width of one beat.
- AWIDTH, 8: memory address width.
- FIFO_DEPTH, 1<<AWIDTH: number of words; must be a power of two.

Ports:
- clk  in  1  clock; all logic is single-clock.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  MAC beat valid. There is no backpressure: every valid beat is consumed.
- wr_data  in  DWIDTH  MAC beat data.
- wr_eop  in  1  last beat of the packet.
- wr_err  in  1  bad packet; sampled only with wr_eop.
- rd_valid  out  1  DMA-side beat available.
- rd_ready  in  1  DMA accepts the beat.
- rd_data  out  DWIDTH  DMA-side data.
- rd_eop  out  1  last beat of the packet.
- mem_write  out  1  memory write strobe.
- mem_waddr  out  AWIDTH  memory write address.
- mem_wdata  out  DWIDTH+1  memory write data; {eop, data}.
- mem_read  out  1  memory read strobe.
- mem_raddr  out  AWIDTH  memory read address.
- mem_rdata  in  DWIDTH+1  memory read data; valid the cycle after mem_read.
- depth_left  out  AWIDTH+1  free words, counting uncommitted words as used.
- full  out  1  depth_left==0.
- empty  out  1  no committed word in memory or in the output buffer.
- pkt_count  out  AWIDTH+1  committed packets not yet fully read.
- drop_count  out  16  dropped packets; saturates at 0xFFFF.

## Operation
- Pointers are AWIDTH+1 bits wide; the MSB is the wrap bit. There are three: w_ptr (speculative write), w_cmt (committed write) and r_ptr (read issue). The memory address is the low AWIDTH bits.
- depth_left = FIFO_DEPTH − (w_ptr − r_ptr), computed modulo 2^(AWIDTH+1).
- Write FSM:
  - IDLE: on wr_valid, write the beat and go to RECV. If the beat also has wr_eop, handle it as EOP, below.
  - RECV: write each valid beat.
  - EOP beat with wr_err=0: set w_cmt to w_ptr+1, increment pkt_count, go to IDLE.
  - EOP beat with wr_err=1: rewind w_ptr to w_cmt, increment drop_count, go to IDLE.
  - Valid beat while full, in IDLE or RECV: do not write it, rewind w_ptr to w_cmt, increment drop_count. If the beat has wr_eop, go to IDLE; otherwise go to DROP.
  - DROP: discard beats until a wr_eop beat arrives, then go to IDLE.
- mem_write = wr_valid && state!=DROP && !full. mem_wdata = {wr_eop, wr_data}.
- Read side: mem_read issues when r_ptr != w_cmt and the output buffer has a free slot, counting any in-flight read. r_ptr increments on each issue.
- Output buffer: 2 entries. The head entry drives rd_valid, rd_data and rd_eop.
- A beat transfers on rd_valid && rd_ready. rd_data and rd_eop hold stable while rd_valid=1 && rd_ready=0.
- pkt_count decrements on a transferred beat with rd_eop. If a commit and an rd_eop transfer happen in the same cycle, pkt_count is unchanged.

## Timing
- Reset values:
  - Pointers: 0.
  - State: IDLE.
  - depth_left: FIFO_DEPTH.
  - full: 0. empty: 1.
  - rd_valid, rd_data, rd_eop: 0.
  - mem_* outputs: 0.
  - pkt_count and drop_count: 0.
- Reset mid-packet loses all contents, including any partial packet.
- Write latency: the memory write happens in the same cycle the beat is presented.
- Commit latency: w_cmt updates on the clock edge after the EOP beat.
- Earliest read: mem_read issues 1 cycle after the commit and rd_valid rises 1 cycle after that, i.e. 2 cycles after the EOP edge.
- With rd_ready held at 1, the read side sustains 1 beat per cycle.
- A rewind frees space on the following edge.
- depth_left, full and empty are registered, consistent with the pointers after each edge.
- Boundary conditions:
  - Exactly FIFO_DEPTH words accepted followed by a valid EOP: the packet commits.
  - FIFO_DEPTH+1 beats of a single packet: the packet is dropped.
  - Wrap-around is correct across the pointer MSB.

## Configuration
- DMA_PKT_FIFO_STATS_EN:
  - Defined: pkt_count and the saturating drop_count are implemented.
  - Undefined: both outputs are tied to 0 and their registers are not built. FIFO behaviour is otherwise identical.

## Structure
- Package dma_pkt_pkg:
  - Write-FSM enum {IDLE, RECV, DROP}.
  - Memory word typedef {eop, data}.
  - DROP_CNT_W=16.
- Sub-module dma_pkt_rd_skid: the 2-entry output buffer. It exposes free-slot and credit signals to the read issue logic.

## Test plan
- **Single packet:** 4-beat packet 0x1..0x4, no error, rd_ready=1 → rd_valid rises 2 cycles after the EOP edge; 4 consecutive beats are read; rd_eop is set on 0x4; pkt_count goes 0→1→0.
- **Errored packet:** 3 beats with wr_err on EOP → nothing readable; drop_count=1; depth_left returns to FIFO_DEPTH.
- **Overflow:** with AWIDTH=4, a 20-beat packet followed by a good 2-beat packet → the first packet is dropped; only the 2-beat packet is read; drop_count=1.
- **Backpressure:** rd_ready toggles every cycle across 3 committed packets → no loss or duplication; data stays stable while stalled; order is preserved.
- **Wrap-around:** stream 40 packets of 5 beats at AWIDTH=4 → all data is read intact across pointer wrap; full is never falsely asserted.
- **Reset mid-packet:** assert rst during beat 2 of a packet → all outputs return to reset values; the next packet is accepted cleanly.

Source files
------------

// File: rtl/dma_pkt_pkg.sv
// Shared types and constants for the packet-aware receive FIFO.
// The pkt_count/drop_count statistics are built only when DMA_PKT_FIFO_STATS_EN is defined.
package dma_pkt_pkg;

  // Write-side packet FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_e;

  localparam int DROP_CNT_W = 16;

  // Saturating increment for the dropped-packet counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/dma_pkt_rd_skid.sv
// Two-entry output buffer between the 1-cycle-latency memory read port and
// the DMA valid/ready interface. Tracks the in-flight read so the issue logic
// never launches a read it cannot land.
module dma_pkt_rd_skid #(
  parameter int DWIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_i,       // read launched this cycle
  input  logic [DWIDTH:0]   rdata_i,       // {eop, data}, valid the cycle after issue
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              eop_o,
  output logic [1:0]        free_slots_o,  // entries not holding data
  output logic              credit_o,      // a new read may be issued this cycle
  output logic              idle_next_o    // buffer and read pipe empty after this edge
);

  // Memory word layout {eop, data}, sized to this instance.
  typedef struct packed {
    logic              eop;
    logic [DWIDTH-1:0] data;
  } mem_word_t;

  mem_word_t  head_q, head_d, tail_q, tail_d, rword;
  logic [1:0] cnt_q, cnt_d;
  logic       inflight_q;
  logic       push, pop;
  logic [2:0] used, limit;

  assign rword   = mem_word_t'(rdata_i);
  assign push    = inflight_q;
  assign pop     = valid_o && ready_i;
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = head_q.data;
  assign eop_o   = head_q.eop;

  // Credit counts the read already in flight; a beat leaving this cycle
  // frees its slot early so back-to-back reads sustain one beat per cycle.
  assign used         = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign limit        = 3'd2 + {2'b00, pop};
  assign credit_o     = (used < limit);
  assign free_slots_o = 2'd2 - cnt_q;
  assign idle_next_o  = (cnt_d == 2'd0) && !issue_i;

  // Next-state of the two entries: head always drives the output.
  // NOTE: every variable gets its default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = rword;
        else               tail_d = rword;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = rword;
        end else begin
          head_d = rword;
        end
      end
      default: ;
    endcase
  end

  // Entry, occupancy and in-flight registers.
  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue_i;
    end
  end

endmodule

// File: rtl/dma_pkt_fifo_exmem.sv
// Store-and-forward packet FIFO with external memory. Beats are written
// speculatively and become readable only once the packet commits on a good
// EOP; errored or overflowing packets are rewound. Optional statistics are
// enabled with DMA_PKT_FIFO_STATS_EN.
module dma_pkt_fifo_exmem
  import dma_pkt_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int AWIDTH     = 8,
  parameter int FIFO_DEPTH = 1 << AWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DWIDTH-1:0]     wr_data,
  input  logic                  wr_eop,
  input  logic                  wr_err,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DWIDTH-1:0]     rd_data,
  output logic                  rd_eop,
  output logic                  mem_write,
  output logic [AWIDTH-1:0]     mem_waddr,
  output logic [DWIDTH:0]       mem_wdata,
  output logic                  mem_read,
  output logic [AWIDTH-1:0]     mem_raddr,
  input  logic [DWIDTH:0]       mem_rdata,
  output logic [AWIDTH:0]       depth_left,
  output logic                  full,
  output logic                  empty,
  output logic [AWIDTH:0]       pkt_count,
  output logic [DROP_CNT_W-1:0] drop_count
);

  typedef logic [AWIDTH:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam ptr_t DEPTH_P = ptr_t'(FIFO_DEPTH);

  wr_state_e state_q, state_d;
  ptr_t      w_ptr_q, w_ptr_d, w_cmt_q, w_cmt_d, r_ptr_q, r_ptr_d;
  ptr_t      depth_q, depth_d;
  logic      full_q, empty_q, empty_d;
  logic      commit, drop, accept;
  logic      issue, credit, idle_next;
  logic [1:0] skid_free_unused;

  // A beat is accepted only outside DROP and with space left; reset gates the
  // strobe so the memory port is quiet while rst is low.
  assign accept    = wr_valid && (state_q != DROP) && !full_q;
  assign mem_write = accept && rst;
  assign mem_waddr = w_ptr_q[AWIDTH-1:0];
  assign mem_wdata = mem_write ? {wr_eop, wr_data} : '0;

  // Write FSM: speculative write pointer, commit on good EOP, rewind on error/overflow.
  always_comb begin
    state_d = state_q;
    w_ptr_d = w_ptr_q;
    w_cmt_d = w_cmt_q;
    commit  = 1'b0;
    drop    = 1'b0;
    if (wr_valid) begin
      unique case (state_q)
        IDLE, RECV: begin
          if (full_q) begin
            w_ptr_d = w_cmt_q;
            drop    = 1'b1;
            state_d = wr_eop ? IDLE : DROP;
          end else if (wr_eop && wr_err) begin
            w_ptr_d = w_cmt_q;
            drop    = 1'b1;
            state_d = IDLE;
          end else if (wr_eop) begin
            w_ptr_d = w_ptr_q + PTR_ONE;
            w_cmt_d = w_ptr_q + PTR_ONE;
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            w_ptr_d = w_ptr_q + PTR_ONE;
            state_d = RECV;
          end
        end
        DROP:    if (wr_eop) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Read issue: only committed words, and only when the output buffer can take them.
  assign issue     = (r_ptr_q != w_cmt_q) && credit;
  assign mem_read  = issue;
  assign mem_raddr = r_ptr_q[AWIDTH-1:0];
  assign r_ptr_d   = issue ? r_ptr_q + PTR_ONE : r_ptr_q;

  // Status flags derived from the next pointers so they match them after each edge.
  assign depth_d = DEPTH_P - (w_ptr_d - r_ptr_d);
  assign empty_d = (w_cmt_d == r_ptr_d) && idle_next;

  // Pointer, FSM and status registers. NOTE: the external buffer is never
  // cleared; reset only rewinds the pointers, which makes all old contents unreachable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      w_ptr_q <= '0;
      w_cmt_q <= '0;
      r_ptr_q <= '0;
      depth_q <= DEPTH_P;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      w_ptr_q <= w_ptr_d;
      w_cmt_q <= w_cmt_d;
      r_ptr_q <= r_ptr_d;
      depth_q <= depth_d;
      full_q  <= (depth_d == '0);
      empty_q <= empty_d;
    end
  end

  assign depth_left = depth_q;
  assign full       = full_q;
  assign empty      = empty_q;

  dma_pkt_rd_skid #(.DWIDTH(DWIDTH)) u_rd_skid (
    .clk          (clk),
    .rst_n        (rst),
    .issue_i      (issue),
    .rdata_i      (mem_rdata),
    .ready_i      (rd_ready),
    .valid_o      (rd_valid),
    .data_o       (rd_data),
    .eop_o        (rd_eop),
    .free_slots_o (skid_free_unused),
    .credit_o     (credit),
    .idle_next_o  (idle_next)
  );

`ifdef DMA_PKT_FIFO_STATS_EN
  ptr_t                  pkt_cnt_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic                  eop_xfer;
  logic                  unused_stats;

  assign eop_xfer     = rd_valid && rd_ready && rd_eop;
  assign unused_stats = ^skid_free_unused;

  // Packet and drop accounting; a commit and a final-beat read cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (commit && !eop_xfer)      pkt_cnt_q <= pkt_cnt_q + PTR_ONE;
      else if (!commit && eop_xfer) pkt_cnt_q <= pkt_cnt_q - PTR_ONE;
      if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = commit ^ drop ^ (^skid_free_unused);
  assign pkt_count    = '0;
  assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_dma_pkt_fifo_exmem.sv
// Self-checking bench for dma_pkt_fifo_exmem with a scoreboard of committed beats.
module tb_dma_pkt_fifo_exmem;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef DMA_PKT_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk, rst;
  logic          wr_valid, wr_eop, wr_err, rd_ready;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, rd_eop, mem_write, mem_read, full, empty;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW:0]   mem_wdata, mem_rdata;
  logic [AW:0]   depth_left, pkt_count;
  logic [15:0]   drop_count;

  dma_pkt_fifo_exmem #(.DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_eop(wr_eop), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_eop(rd_eop),
    .mem_write(mem_write), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .depth_left(depth_left), .full(full), .empty(empty),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memory: registered read, one cycle latency.
  logic [DW:0] mem [DEPTH];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_write) mem[mem_waddr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_raddr];
  end

  int          n_checks = 0;
  int          n_fails  = 0;
  int          exp_drop = 0;
  int          ready_mode = 1;   // 0 low, 1 high, 2 toggle
  bit          watch_full = 1'b0;
  bit          full_seen  = 1'b0;
  logic [DW:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input bit eop, input bit err);
    wr_valid = 1'b1;
    wr_data  = DW'(d);
    wr_eop   = eop;
    wr_err   = err;
    tick();
  endtask

  task automatic send_pkt(input int base, input int len, input bit err, input bit ok);
    logic [DW:0] tmp [$];
    for (int i = 0; i < len; i++) begin
      beat(base + i, i == len - 1, err && (i == len - 1));
      tmp.push_back({i == len - 1, DW'(base + i)});
    end
    wr_valid = 1'b0;
    wr_eop   = 1'b0;
    wr_err   = 1'b0;
    if (ok) foreach (tmp[k]) sb_q.push_back(tmp[k]);
    else if (exp_drop < 16'hFFFF) exp_drop++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || !empty) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(n < budget), 32'd1);
    check({tag, "_depth"}, 32'(depth_left), DEPTH);
    check({tag, "_drop"}, 32'(drop_count), STATS ? exp_drop : 0);
  endtask

  // rd_ready driver.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_ready = (ready_mode == 1) || ((ready_mode == 2) && !rd_ready);
    end
  end

  // Scoreboard consumer and stall-stability monitor, sampled mid-cycle.
  bit          stall_prev = 1'b0;
  logic [DW:0] held;
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", 32'({rd_eop, rd_data}), 32'(held));
      if (rd_valid && rd_ready) begin
        if (sb_q.size() == 0) begin
          check("rd_unexpected", 32'({rd_eop, rd_data}), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e[DW-1:0]));
          check("rd_eop", 32'(rd_eop), 32'(e[DW]));
        end
      end
      stall_prev = rd_valid && !rd_ready;
      held       = {rd_eop, rd_data};
      if (watch_full && full) full_seen = 1'b1;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_rd_data"}, 32'({rd_eop, rd_data}), 0);
    check({tag, "_mem"}, 32'({mem_write, mem_read, mem_waddr, mem_raddr}), 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_depth"}, 32'(depth_left), DEPTH);
    check({tag, "_flags"}, 32'({full, empty}), 32'b01);
    check({tag, "_stats"}, 32'({pkt_count, drop_count}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_eop = 1'b0; wr_err = 1'b0;
    tick(); tick();
    check_reset_values("reset");
    rst = 1'b1;
    tick();

    // Single packet: latency, throughput and pkt_count.
    ready_mode = 1;
    for (int i = 1; i <= 4; i++) sb_q.push_back({i == 4, DW'(i)});
    beat(1, 0, 0); beat(2, 0, 0); beat(3, 0, 0); beat(4, 1, 0);
    wr_valid = 1'b0; wr_eop = 1'b0;
    check("t1_pkt_1", 32'(pkt_count), STATS ? 1 : 0);
    check("t1_empty", 32'(empty), 0);
    check("t1_rv_e0", 32'(rd_valid), 0);
    tick();
    check("t1_rv_e1", 32'(rd_valid), 0);
    tick();
    check("t1_rv_e2", 32'(rd_valid), 1);
    check("t1_first", 32'(rd_data), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_stream", 32'(rd_valid), 1);
    end
    drain("t1", 50);
    check("t1_pkt_0", 32'(pkt_count), 0);

    // Errored packet is rewound and dropped.
    send_pkt(16'h10, 3, 1, 0);
    tick();
    check("t2_rv", 32'(rd_valid), 0);
    check("t2_empty", 32'(empty), 1);
    drain("t2", 20);

    // Exactly FIFO_DEPTH beats commit; reader stalled.
    ready_mode = 0;
    send_pkt(16'h100, DEPTH, 0, 1);
    check("t3_full", 32'(full), 1);
    tick(); tick(); tick();
    check("t3_pkt", 32'(pkt_count), STATS ? 1 : 0);
    check("t3_depth_skid", 32'(depth_left), 2);
    ready_mode = 1;
    drain("t3", 100);

    // FIFO_DEPTH+1 beats: dropped.
    send_pkt(16'h200, DEPTH + 1, 0, 0);
    tick();
    check("t4_empty", 32'(empty), 1);
    drain("t4", 20);

    // Overflow then a good short packet.
    send_pkt(16'h300, 20, 0, 0);
    send_pkt(16'h400, 2, 0, 1);
    drain("t5", 50);

    // Backpressure across three packets.
    ready_mode = 2;
    send_pkt(16'h500, 3, 0, 1);
    send_pkt(16'h510, 5, 0, 1);
    send_pkt(16'h520, 4, 0, 1);
    drain("t6", 200);

    // Wrap-around: 40 back-to-back 5-beat packets.
    ready_mode = 1;
    watch_full = 1'b1;
    for (int p = 0; p < 40; p++) send_pkt(16'h1000 + p * 16, 5, 0, 1);
    drain("t7", 500);
    watch_full = 1'b0;
    check("t7_no_full", 32'(full_seen), 0);

    // Reset during beat 2 of a packet.
    beat(16'h600, 0, 0);
    wr_data = 16'h601;
    #3;
    rst = 1'b0;
    #1;
    wr_valid = 1'b0;
    check_reset_values("t8_in_reset");
    tick();
    rst = 1'b1;
    exp_drop = 0;
    tick();
    send_pkt(16'h700, 3, 0, 1);
    drain("t8", 50);
    check("t8_pkt", 32'(pkt_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
